// File: rtl/pc_sequencer_if.sv
// Bundle of all program-counter sequencer control and status signals.
// Latency: none (wires only).
// Backpressure: none here; the sequencer's stall and enable inputs are scalar ports.
// master: the instruction pipeline driving control and reading status.
// slave : the pc_sequencer itself.
interface pc_sequencer_if #(
  parameter int DATABITWIDTH = 16,
  parameter int RASDEPTH     = 8
);
  logic                      PCEn;
  logic                      StallEn;
  logic                      BranchEn;
  logic                      BranchRelative;
  logic [DATABITWIDTH-1:0]   ComparisonValue;
  logic [DATABITWIDTH-1:0]   BranchDest;
  logic                      JumpEn;
  logic                      LinkEn;
  logic                      ReturnEn;
  logic [DATABITWIDTH-1:0]   JumpDest;
  logic                      FaultClear;
  logic [DATABITWIDTH-1:0]   InstructionAddrOut;
  logic [DATABITWIDTH-1:0]   JumpAndLinkAddrOut;
  logic [$clog2(RASDEPTH):0] StackDepthOut;
  logic                      StackEmpty;
  logic                      StackFull;
  logic [1:0]                FaultOut;

  modport master (
    output PCEn, StallEn, BranchEn, BranchRelative, ComparisonValue, BranchDest,
           JumpEn, LinkEn, ReturnEn, JumpDest, FaultClear,
    input  InstructionAddrOut, JumpAndLinkAddrOut, StackDepthOut,
           StackEmpty, StackFull, FaultOut
  );

  modport slave (
    input  PCEn, StallEn, BranchEn, BranchRelative, ComparisonValue, BranchDest,
           JumpEn, LinkEn, ReturnEn, JumpDest, FaultClear,
    output InstructionAddrOut, JumpAndLinkAddrOut, StackDepthOut,
           StackEmpty, StackFull, FaultOut
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with branch/jump/call/return and a circular return-address stack.
// Latency: next PC registered one edge after an advance; JumpAndLinkAddrOut is combinational.
// Backpressure: StallEn or clk_en low holds PC, stack and depth; sync_rst overrides everything.
// Ports: clk, clk_en, sync_rst scalar; bus (slave) carries control inputs and PC/stack/fault status.
module pc_sequencer #(
  parameter int                    DATABITWIDTH = 16,
  parameter int                    RASDEPTH     = 8,
  parameter logic [DATABITWIDTH-1:0] RESETVECTOR  = '0
) (
  input  logic           clk,
  input  logic           clk_en,
  input  logic           sync_rst,
  pc_sequencer_if.slave  bus
);
  localparam int                 AW         = $clog2(RASDEPTH);
  localparam logic [DATABITWIDTH-1:0] ONE   = {{(DATABITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]        FULL_DEPTH = (AW+1)'(RASDEPTH);

  logic [DATABITWIDTH-1:0] pc;
  logic [DATABITWIDTH-1:0] ras [RASDEPTH];
  logic [AW-1:0]           top;
  logic [AW:0]             depth;
  logic [1:0]              fault;

  logic [DATABITWIDTH-1:0] pc_inc, br_tgt, next_pc;
  logic [AW-1:0]           top_inc, top_dec;
  logic                    advance, taken, empty, full, do_pop, do_push;
  logic [1:0]              fault_set, fault_nxt;

  always_comb begin
    advance = bus.PCEn & ~bus.StallEn & clk_en;
    pc_inc  = pc + ONE;
    br_tgt  = bus.BranchRelative ? (pc + bus.BranchDest) : bus.BranchDest;
    taken   = bus.BranchEn & (bus.ComparisonValue == '0);
    empty   = (depth == '0);
    full    = (depth == FULL_DEPTH);
    top_inc = top + AW'(1);
    top_dec = top - AW'(1);
    // Return wins over everything, so a concurrent jump/link is dropped.
    do_pop  = advance & bus.ReturnEn;
    do_push = advance & ~bus.ReturnEn & bus.JumpEn & bus.LinkEn;

    next_pc = pc_inc;
    if (do_pop)
      next_pc = empty ? RESETVECTOR : ras[top];
    else if (bus.JumpEn)
      next_pc = bus.JumpDest;
    else if (taken)
      next_pc = br_tgt;

    fault_set = {do_pop & empty, do_push & full};
    // A fault raised in the clearing cycle survives the clear.
    fault_nxt = ((clk_en & bus.FaultClear) ? 2'b00 : fault) | fault_set;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc    <= RESETVECTOR;
      top   <= '0;
      depth <= '0;
      fault <= '0;
    end else begin
      fault <= fault_nxt;
      if (advance)
        pc <= next_pc;
      // When full, top+1 is the oldest slot, so pushing overwrites it.
      if (do_push) begin
        top <= top_inc;
        if (!full)
          depth <= depth + (AW+1)'(1);
      end else if (do_pop && !empty) begin
        top   <= top_dec;
        depth <= depth - (AW+1)'(1);
      end
    end
  end

  // Entry storage carries no reset; only pointer and depth define validity.
  always_ff @(posedge clk) begin
    if (!sync_rst && do_push)
      ras[top_inc] <= pc_inc;
  end

  assign bus.InstructionAddrOut = pc;
  assign bus.JumpAndLinkAddrOut = pc_inc;
  assign bus.StackDepthOut      = depth;
  assign bus.StackEmpty         = empty;
  assign bus.StackFull          = full;
  assign bus.FaultOut           = fault;
endmodule
